regfile_scoreboard: RTL and testbench

Pending-write scoreboard and issue interlock for the decode stage. Tracks outstanding register-file writes between decode and writeback, and withholds issue of any instruction whose source or destination registers conflict with in-flight writes. Its stall output gates the PC write enable and the decode/execute pipeline register. Writeback retire strobes clear entries; a flush empties the table.

---
 rtl/regfile_scoreboard_if.sv | 31 +++
 rtl/regfile_scoreboard.sv | 117 +++++++++++
 tb/tb_regfile_scoreboard.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle between the issue stage and the pending-write scoreboard.
// master: pipeline side driving decode/retire; slave: the scoreboard.
interface regfile_scoreboard_if;
    logic        dec_valid;
    logic [4:0]  dec_rs;
    logic [4:0]  dec_rt;
    logic        dec_uses_rs;
    logic        dec_uses_rt;
    logic        dec_writes;
    logic [4:0]  dec_dst;
    logic        dec_ready;
    logic        pc_stall;
    logic        wb_valid;
    logic [4:0]  wb_dst;
    logic        flush;
    logic [31:0] busy;
    logic [3:0]  inflight;
    logic        err_underflow;

    modport master (
        output dec_valid, dec_rs, dec_rt, dec_uses_rs, dec_uses_rt, dec_writes, dec_dst,
        output wb_valid, wb_dst, flush,
        input  dec_ready, pc_stall, busy, inflight, err_underflow
    );

    modport slave (
        input  dec_valid, dec_rs, dec_rt, dec_uses_rs, dec_uses_rt, dec_writes, dec_dst,
        input  wb_valid, wb_dst, flush,
        output dec_ready, pc_stall, busy, inflight, err_underflow
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard and issue interlock for decode; per-register write counters.
// Optional macro SB_RETIRE_BYPASS_EN lets a same-cycle retire release a RAW stall.
module regfile_scoreboard #(
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input logic                 clk,
    input logic                 rst,
    regfile_scoreboard_if.slave sb
);

    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [3:0]       InflMax = 4'(MAX_INFLIGHT);

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [3:0]       inflight_q, inflight_d;
    logic [31:0]      busy_q, busy_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] rs_cnt, rt_cnt, dst_cnt, wb_cnt;
    logic             rs_bypass, rt_bypass;
    logic             raw_rs, raw_rt, track, sat, cap;
    logic             dec_ready;
    logic             issue_trk, retire, retire_ok, underflow;

    // Issue interlock: combinational from current state and the decode fields.
    always_comb begin
        rs_cnt  = cnt_q[sb.dec_rs];
        rt_cnt  = cnt_q[sb.dec_rt];
        dst_cnt = cnt_q[sb.dec_dst];
`ifdef SB_RETIRE_BYPASS_EN
        // Last pending write retiring now; register-file write-through supplies the data.
        rs_bypass = (rs_cnt == CntOne) && sb.wb_valid && (sb.wb_dst == sb.dec_rs);
        rt_bypass = (rt_cnt == CntOne) && sb.wb_valid && (sb.wb_dst == sb.dec_rt);
`else
        rs_bypass = 1'b0;
        rt_bypass = 1'b0;
`endif
        raw_rs    = sb.dec_uses_rs && (sb.dec_rs != 5'd0) && (rs_cnt != '0) && !rs_bypass;
        raw_rt    = sb.dec_uses_rt && (sb.dec_rt != 5'd0) && (rt_cnt != '0) && !rt_bypass;
        track     = sb.dec_writes && (sb.dec_dst != 5'd0);
        sat       = track && (dst_cnt == CntMax);
        cap       = track && (inflight_q == InflMax);
        dec_ready = !(raw_rs || raw_rt || sat || cap);
    end

    always_comb begin
        issue_trk = sb.dec_valid && dec_ready && track;
        retire    = sb.wb_valid && (sb.wb_dst != 5'd0);
        wb_cnt    = cnt_q[sb.wb_dst];
        retire_ok = retire && (wb_cnt != '0);
        underflow = retire && (wb_cnt == '0);

        cnt_d      = cnt_q;
        inflight_d = inflight_q;
        err_d      = err_q | underflow;
        busy_d     = '0;

        for (int i = 1; i < 32; i++) begin
            // Same-register issue and retire cancel out.
            if (issue_trk && (sb.dec_dst == 5'(i)) &&
                !(retire_ok && (sb.wb_dst == 5'(i)))) begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end else if (retire_ok && (sb.wb_dst == 5'(i)) &&
                         !(issue_trk && (sb.dec_dst == 5'(i)))) begin
                cnt_d[i] = cnt_q[i] - CntOne;
            end
        end
        cnt_d[0] = '0;

        if (issue_trk && !retire_ok) begin
            inflight_d = inflight_q + 4'd1;
        end else if (retire_ok && !issue_trk) begin
            inflight_d = inflight_q - 4'd1;
        end

        // Flush overrides both events and leaves the error flag alone.
        if (sb.flush) begin
            for (int i = 0; i < 32; i++) begin
                cnt_d[i] = '0;
            end
            inflight_d = 4'd0;
            err_d      = err_q;
        end

        for (int i = 1; i < 32; i++) begin
            busy_d[i] = (cnt_d[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
            inflight_q <= 4'd0;
            busy_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign sb.dec_ready     = dec_ready;
    assign sb.pc_stall      = sb.dec_valid && !dec_ready;
    assign sb.busy          = busy_q;
    assign sb.inflight      = inflight_q;
    assign sb.err_underflow = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: a driver pushes expectations from a pending-write
// list model into a queue; a monitor pops and compares against the DUT each cycle.
module tb_regfile_scoreboard;

    localparam int unsigned CNT_W        = 2;
    localparam int unsigned MAX_INFLIGHT = 4;
    localparam int          CntMax       = (1 << CNT_W) - 1;

    typedef struct {
        string       tag;
        logic        ready;
        logic        stall;
        logic [31:0] busy;
        logic [3:0]  infl;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_scoreboard_if sb ();

    regfile_scoreboard #(
        .CNT_W        (CNT_W),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    exp_t exp_q[$];
    int   pend[$];      // destination register of every tracked in-flight write
    bit   m_err;
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic int cnt_of(int r);
        int c = 0;
        foreach (pend[k]) if (pend[k] == r) c++;
        return c;
    endfunction

    function automatic bit src_conflict(bit uses, int r, bit wbv, int wbd);
        int c   = cnt_of(r);
        bit byp = 1'b0;
`ifdef SB_RETIRE_BYPASS_EN
        byp = (c == 1) && wbv && (wbd == r);
`endif
        return uses && (r != 0) && (c != 0) && !byp;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic step(input string tag, input bit v, input int rs, input int rt,
                        input bit urs, input bit urt, input bit wr, input int dst,
                        input bit wbv, input int wbd, input bit fl, input bit rv);
        bit   ready, track, sat, cap;
        int   idx;
        exp_t e;
        @(negedge clk);
        rst            = rv;
        sb.dec_valid   = v;
        sb.dec_rs      = 5'(rs);
        sb.dec_rt      = 5'(rt);
        sb.dec_uses_rs = urs;
        sb.dec_uses_rt = urt;
        sb.dec_writes  = wr;
        sb.dec_dst     = 5'(dst);
        sb.wb_valid    = wbv;
        sb.wb_dst      = 5'(wbd);
        sb.flush       = fl;
        if (!rv) begin
            pend.delete();
            m_err = 1'b0;
        end
        track = wr && (dst != 0);
        sat   = track && (cnt_of(dst) == CntMax);
        cap   = track && (pend.size() == MAX_INFLIGHT);
        ready = !(src_conflict(urs, rs, wbv, wbd) || src_conflict(urt, rt, wbv, wbd) ||
                  sat || cap);
        e.tag   = tag;
        e.ready = ready;
        e.stall = v && !ready;
        e.busy  = '0;
        for (int r = 1; r < 32; r++) e.busy[r] = (cnt_of(r) != 0);
        e.infl  = 4'(pend.size());
        e.err   = m_err;
        #1 exp_q.push_back(e);
        if (rv) begin
            if (fl) begin
                pend.delete();
            end else begin
                if (wbv && wbd != 0) begin
                    idx = -1;
                    foreach (pend[k]) if (idx < 0 && pend[k] == wbd) idx = k;
                    if (idx >= 0) pend.delete(idx);
                    else m_err = 1'b1;
                end
                if (v && ready && track) pend.push_back(dst);
            end
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic wr_reg(input string tag, input int dst);
        step(tag, 1, 0, 0, 0, 0, 1, dst, 0, 0, 0, 1);
    endtask

    // Monitor: every cycle the DUT outputs are valid; compare against each queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, " dec_ready"},     32'(sb.dec_ready),     32'(e.ready));
                chk({e.tag, " pc_stall"},      32'(sb.pc_stall),      32'(e.stall));
                chk({e.tag, " busy"},          sb.busy,               e.busy);
                chk({e.tag, " inflight"},      32'(sb.inflight),      32'(e.infl));
                chk({e.tag, " err_underflow"}, 32'(sb.err_underflow), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v, rs, rt, urs, urt, wr, dst, wbv, wbd, fl, rv;
        sb.dec_valid = 0; sb.dec_rs = 0; sb.dec_rt = 0; sb.dec_uses_rs = 0;
        sb.dec_uses_rt = 0; sb.dec_writes = 0; sb.dec_dst = 0;
        sb.wb_valid = 0; sb.wb_dst = 0; sb.flush = 0;
        m_err = 0;

        step("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("post_reset");

        // RAW on r5: stall three cycles, then the retire cycle, then issue.
        wr_reg("w5", 5);
        repeat (3) step("raw5", 1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        step("raw5_wb", 1, 5, 0, 1, 0, 0, 0, 1, 5, 0, 1);
        step("raw5_go", 1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        idle("raw5_done");

        // r0 is never tracked nor checked.
        wr_reg("r0_w", 0);
        step("r0_r", 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1);
        idle("r0_done");

        // WAW up to saturation on r7.
        repeat (3) wr_reg("w7", 7);
        wr_reg("w7_sat", 7);
        step("w7_sat_wb", 1, 0, 0, 0, 0, 1, 7, 1, 7, 0, 1);
        wr_reg("w7_go", 7);
        idle("w7_hold");
        step("flush7", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle("flush7_done");

        // Capacity: four in flight blocks a fifth until a retire has taken effect.
        for (int r = 1; r <= 4; r++) wr_reg("wcap", r);
        wr_reg("w9_cap", 9);
        step("w9_cap_wb", 1, 0, 0, 0, 0, 1, 9, 1, 2, 0, 1);
        wr_reg("w9_go", 9);
        idle("cap_hold");
        step("flush_cap", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle("flush_cap_done");

        // Simultaneous issue and retire of r3, then flush.
        wr_reg("w3", 3);
        step("w3_wb3", 1, 0, 0, 0, 0, 1, 3, 1, 3, 0, 1);
        idle("w3_hold");
        step("flush3", 1, 0, 0, 0, 0, 1, 6, 1, 3, 1, 1);
        idle("flush3_done");

        // Underflow is sticky; asynchronous reset clears everything.
        step("uf12", 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 1);
        idle("uf_sticky");
        step("uf_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        wr_reg("w20", 20);
        wr_reg("w21", 21);
        idle("pending2");
        step("arst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("arst_done");

        // Randomized traffic on a small register window to provoke conflicts.
        for (int n = 0; n < 600; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            rs  = $urandom_range(0, 7);
            rt  = $urandom_range(0, 7);
            urs = $urandom_range(0, 1);
            urt = $urandom_range(0, 1);
            wr  = ($urandom_range(0, 2) != 0);
            dst = $urandom_range(0, 7);
            wbv = ($urandom_range(0, 2) == 0);
            if (pend.size() > 0 && $urandom_range(0, 3) != 0)
                wbd = pend[$urandom_range(0, pend.size() - 1)];
            else
                wbd = $urandom_range(0, 7);
            fl  = ($urandom_range(0, 63) == 0);
            rv  = ($urandom_range(0, 199) != 0);
            step("rand", v, rs, rt, urs, urt, wr, dst, wbv, wbd, fl, rv);
        end
        idle("final");

        @(negedge clk);
        #3;
        chk("queue drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
